// File: rtl/dtack_gen.sv
// dtack_gen: 68000 bus-cycle terminator with per-region wait states.
// Optional watchdog/BERR path built when DTACK_GEN_BERR_EN is defined.
module dtack_gen #(
    parameter int unsigned WS_ROM  = 2,
    parameter int unsigned WS_RAM  = 0,
    parameter int unsigned WS_IO   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_in,
    input  logic reset,
    input  logic as_n,
    input  logic sel_rom,
    input  logic sel_ram,
    input  logic sel_io,
    output logic dtack_n,
    output logic berr_n,
    output logic cyc_active
);

`ifdef DTACK_GEN_BERR_EN
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACK,
        NOSEL,
        BERR
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        NOSEL
    } state_t;
`endif

    state_t     state;
    state_t     state_nx;
    logic       sync1;
    logic       sync2;
    logic       as_s;
    logic [3:0] ws_cnt;
    logic [3:0] ws_nx;
    logic       dtack_nx;

`ifdef DTACK_GEN_BERR_EN
    logic [7:0] wdt;
    logic [7:0] wdt_nx;
    logic       berr_q;
    logic       berr_nx;
    logic       wdt_exp;
    logic [7:0] wdt_inc;

    // Watchdog expires once TIMEOUT full cycles have been counted
    assign wdt_exp = (wdt == 8'(TIMEOUT));
    assign wdt_inc = (wdt == 8'hFF) ? wdt : wdt + 8'd1;
    assign berr_n  = berr_q;
`else
    assign berr_n = 1'b1;
`endif

    assign as_s = ~sync2;

    // Two-flop synchroniser for the asynchronous address strobe
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= as_n;
            sync2 <= sync1;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_nx = state;
        ws_nx    = ws_cnt;
        dtack_nx = dtack_n;
`ifdef DTACK_GEN_BERR_EN
        wdt_nx   = wdt;
        berr_nx  = berr_q;
`endif
        unique case (state)
            IDLE: begin
                dtack_nx = 1'b1;
`ifdef DTACK_GEN_BERR_EN
                wdt_nx   = 8'd0;
                berr_nx  = 1'b1;
`endif
                if (as_s) begin
                    if (sel_rom) begin
                        state_nx = WAIT;
                        ws_nx    = 4'(WS_ROM);
                    end else if (sel_ram) begin
                        state_nx = WAIT;
                        ws_nx    = 4'(WS_RAM);
                    end else if (sel_io) begin
                        state_nx = WAIT;
                        ws_nx    = 4'(WS_IO);
                    end else begin
                        state_nx = NOSEL;
                    end
                end
            end
            WAIT: begin
`ifdef DTACK_GEN_BERR_EN
                wdt_nx = wdt_inc;
`endif
                if (!as_s) begin
                    state_nx = IDLE;
                end else if (ws_cnt == 4'd0) begin
                    state_nx = ACK;
                    dtack_nx = 1'b0;
`ifdef DTACK_GEN_BERR_EN
                end else if (wdt_exp) begin
                    state_nx = BERR;
                    berr_nx  = 1'b0;
`endif
                end else begin
                    ws_nx = ws_cnt - 4'd1;
                end
            end
            ACK: begin
                if (!as_s) begin
                    state_nx = IDLE;
                    dtack_nx = 1'b1;
                end
            end
            NOSEL: begin
`ifdef DTACK_GEN_BERR_EN
                wdt_nx = wdt_inc;
`endif
                if (!as_s) begin
                    state_nx = IDLE;
`ifdef DTACK_GEN_BERR_EN
                end else if (wdt_exp) begin
                    state_nx = BERR;
                    berr_nx  = 1'b0;
`endif
                end
            end
`ifdef DTACK_GEN_BERR_EN
            BERR: begin
                if (!as_s) begin
                    state_nx = IDLE;
                    berr_nx  = 1'b1;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                dtack_nx = 1'b1;
            end
        endcase
    end

    // State register with registered strobe outputs
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            ws_cnt     <= 4'd0;
            dtack_n    <= 1'b1;
            cyc_active <= 1'b0;
        end else begin
            state      <= state_nx;
            ws_cnt     <= ws_nx;
            dtack_n    <= dtack_nx;
            cyc_active <= (state_nx != IDLE);
        end
    end

`ifdef DTACK_GEN_BERR_EN
    // Watchdog counter and bus-error output
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wdt    <= 8'd0;
            berr_q <= 1'b1;
        end else begin
            wdt    <= wdt_nx;
            berr_q <= berr_nx;
        end
    end
`endif

endmodule
